level_countdown_timer: RTL and testbench

Parametrised per-level countdown timer with an on-screen drain bar, for the game-logic layer. It counts whole seconds from `frame_clk_rising_edge` ticks and supports pause, bonus-time injection and a low-time warning. It raises a one-cycle expiry pulse for the death/round logic. Its pixel classification feeds the colour mapper alongside the other sprite `is_*` flags.

---
 rtl/timer_pkg.sv | 7 +
 rtl/timer_bar_pixel.sv | 31 +++
 rtl/level_countdown_timer.sv | 74 +++++++
 tb/tb_level_countdown_timer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and is_timer bit positions for the level timer
package timer_pkg;
   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} timer_state_t;
   localparam int TMR_IN = 0;
   localparam int TMR_FILL = 1;
   localparam int TMR_WARN = 2;
endpackage

// File: rtl/timer_bar_pixel.sv
// timer_bar_pixel: classifies the current pixel against the draining timer bar
module timer_bar_pixel
   import timer_pkg::*;
#(
   parameter int BAR_X = 420,
   parameter int BAR_Y = 450,
   parameter int BAR_H = 10,
   parameter int PIX_PER_SEC = 2,
   parameter int MAX_TIME = 30,
   parameter int TIME_W = 8,
   parameter int WARN_TIME = 5
) (
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic [TIME_W-1:0] TimeLeft,
   input  logic              Active,
   output logic [2:0]        is_timer
);
   int dx, dy, fillW;
   logic inBar;
   always_comb begin
      dx = int'(DrawX) - BAR_X;
      dy = int'(DrawY) - BAR_Y;
      fillW = int'(TimeLeft) * PIX_PER_SEC;
      inBar = Active && dx >= 0 && dx < MAX_TIME * PIX_PER_SEC && dy >= 0 && dy < BAR_H;
      is_timer = '0;
      is_timer[TMR_IN] = inBar;
      is_timer[TMR_FILL] = inBar && dx < fillW;
      is_timer[TMR_WARN] = inBar && int'(TimeLeft) <= WARN_TIME;
   end
endmodule

// File: rtl/level_countdown_timer.sv
// level_countdown_timer: per-level seconds countdown with pause, bonus time, expiry pulse and bar pixels
module level_countdown_timer
   import timer_pkg::*;
#(
   parameter int MAX_TIME = 30,
   parameter int TIME_W = 8,
   parameter int FRAMES_PER_SEC = 60,
   parameter int WARN_TIME = 5,
   parameter int BAR_X = 420,
   parameter int BAR_Y = 450,
   parameter int PIX_PER_SEC = 2,
   parameter int BAR_H = 10
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              frame_clk_rising_edge,
   input  logic              Load,
   input  logic              Stop,
   input  logic              Hold,
   input  logic              AddTime,
   input  logic [TIME_W-1:0] AddAmount,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   output logic [TIME_W-1:0] TimeLeft,
   output logic              Expired,
   output logic              Running,
   output logic [2:0]        is_timer
);
   localparam int SUB_W = FRAMES_PER_SEC > 1 ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(FRAMES_PER_SEC - 1);
   localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);
   timer_state_t state;
   logic [SUB_W-1:0] subCnt;
   logic active, count, wrap, expire;
   logic [TIME_W-1:0] decTime, newTime;
   logic [TIME_W:0] sum;
   always_comb begin
      active = state == RUN || state == PAUSED;
      count = state == RUN && !Hold && frame_clk_rising_edge;
      wrap = count && subCnt == '0;
      decTime = wrap ? TimeLeft - TIME_W'(1) : TimeLeft;
      sum = {1'b0, decTime} + {1'b0, AddAmount};
      newTime = !AddTime ? decTime : sum > {1'b0, MAX_T} ? MAX_T : sum[TIME_W-1:0];
      expire = active && newTime == '0;
   end
   always_ff @(posedge Clk) begin
      if (!Reset || Stop || Load) begin
         state <= (Reset && !Stop) ? RUN : IDLE;
         Running <= Reset && !Stop;
         TimeLeft <= MAX_T;
         subCnt <= SUB_MAX;
         Expired <= 1'b0;
      end else begin
         Expired <= 1'b0;
         if (active) begin
            TimeLeft <= newTime;
            if (count) subCnt <= wrap ? SUB_MAX : subCnt - SUB_W'(1);
            state <= expire ? EXPIRED : Hold ? PAUSED : RUN;
            Running <= !expire && !Hold;
            Expired <= expire;
         end
      end
   end
   timer_bar_pixel #(
      .BAR_X(BAR_X), .BAR_Y(BAR_Y), .BAR_H(BAR_H), .PIX_PER_SEC(PIX_PER_SEC),
      .MAX_TIME(MAX_TIME), .TIME_W(TIME_W), .WARN_TIME(WARN_TIME)
   ) barPixel (
      .DrawX(DrawX),
      .DrawY(DrawY),
      .TimeLeft(TimeLeft),
      .Active(state != IDLE),
      .is_timer(is_timer)
   );
endmodule

// File: tb/tb_level_countdown_timer.sv
// tb_level_countdown_timer: directed and random checks against a seconds/frames reference model
module tb_level_countdown_timer;
   localparam int MAXT = 5, FPS = 4, WARN = 2, PPS = 2, BX = 420, BY = 450, BH = 10;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;
   logic Clk = 0, Reset = 0, tick = 0, Load = 0, Stop = 0, Hold = 0, AddTime = 0;
   logic [7:0] AddAmount = 0;
   logic [9:0] DrawX = 0, DrawY = 0;
   logic [7:0] TimeLeft;
   logic Expired, Running;
   logic [2:0] is_timer;
   int checks = 0, errors = 0;
   int mMode = M_IDLE, mTime = MAXT, mElapsed = 0;
   bit mExp = 0;

   level_countdown_timer #(
      .MAX_TIME(MAXT), .TIME_W(8), .FRAMES_PER_SEC(FPS), .WARN_TIME(WARN),
      .BAR_X(BX), .BAR_Y(BY), .PIX_PER_SEC(PPS), .BAR_H(BH)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_clk_rising_edge(tick), .Load(Load), .Stop(Stop),
      .Hold(Hold), .AddTime(AddTime), .AddAmount(AddAmount), .DrawX(DrawX), .DrawY(DrawY),
      .TimeLeft(TimeLeft), .Expired(Expired), .Running(Running), .is_timer(is_timer)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Seconds remaining plus frames elapsed within the current second.
   task automatic modelStep();
      if (!Reset || Stop || Load) begin
         mMode = (Reset && !Stop) ? M_RUN : M_IDLE;
         mTime = MAXT;
         mElapsed = 0;
         mExp = 0;
      end else begin
         mExp = 0;
         if (mMode == M_RUN || mMode == M_PAUSED) begin
            if (mMode == M_RUN && !Hold && tick) begin
               mElapsed++;
               if (mElapsed == FPS) begin
                  mElapsed = 0;
                  mTime--;
               end
            end
            if (AddTime) mTime = (mTime + int'(AddAmount) > MAXT) ? MAXT : mTime + int'(AddAmount);
            if (mTime == 0) begin
               mMode = M_EXP;
               mExp = 1;
            end else mMode = Hold ? M_PAUSED : M_RUN;
         end
      end
   endtask

   function automatic logic [2:0] expPix();
      int dx = int'(DrawX) - BX;
      int dy = int'(DrawY) - BY;
      bit inb = mMode != M_IDLE && dx >= 0 && dx < MAXT * PPS && dy >= 0 && dy < BH;
      return {inb && mTime <= WARN, inb && dx < mTime * PPS, inb};
   endfunction

   task automatic checkAll(input string tag);
      check({tag, ".time"}, TimeLeft, mTime);
      check({tag, ".running"}, Running, mMode == M_RUN);
      check({tag, ".expired"}, Expired, mExp);
      check({tag, ".pix"}, is_timer, expPix());
   endtask

   task automatic cycle(input string tag);
      modelStep();
      @(posedge Clk);
      #1;
      checkAll(tag);
      Reset = 1; tick = 0; Load = 0; Stop = 0; AddTime = 0; AddAmount = 0;
   endtask

   task automatic ticks(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         tick = 1;
         cycle(tag);
      end
   endtask

   initial begin
      DrawX = 10'(BX + 1);
      DrawY = 10'(BY + 1);
      cycle("reset");
      cycle("reset");
      check("reset.time", TimeLeft, 5);
      check("reset.running", Running, 0);
      check("reset.pix", is_timer, 0);

      Load = 1; cycle("load");
      for (int i = 1; i <= 20; i++) begin
         tick = 1; cycle("basic");
         check("basic.seconds", TimeLeft, 5 - i / 4);
         check("basic.pulse", Expired, i == 20);
      end
      ticks(3, "basic.after");
      check("basic.hold0", TimeLeft, 0);

      Load = 1; cycle("pause.load");
      ticks(2, "pause.pre");
      Hold = 1;
      ticks(10, "pause.hold");
      check("pause.frozen", TimeLeft, 5);
      Hold = 0; cycle("pause.resume");
      ticks(2, "pause.post");
      check("pause.after", TimeLeft, 4);

      Load = 1; cycle("bonus.load");
      ticks(8, "bonus.run");
      check("bonus.at3", TimeLeft, 3);
      AddTime = 1; AddAmount = 4; cycle("bonus.sat");
      check("bonus.saturated", TimeLeft, 5);
      Load = 1; cycle("rescue.load");
      ticks(19, "rescue.run");
      check("rescue.at1", TimeLeft, 1);
      tick = 1; AddTime = 1; AddAmount = 2; cycle("rescue.add");
      check("rescue.time", TimeLeft, 2);
      check("rescue.noexp", Expired, 0);
      check("rescue.running", Running, 1);

      Stop = 1; Load = 1; cycle("prio.stopload");
      check("prio.idle", Running, 0);
      Load = 1; cycle("prio.load");
      ticks(4, "prio.run");
      Load = 1; AddTime = 1; AddAmount = 3; tick = 1; cycle("prio.loadadd");
      check("prio.loadadd.time", TimeLeft, 5);

      Load = 1; cycle("pix.load");
      ticks(12, "pix.run");
      DrawY = 10'(BY);
      DrawX = 10'(BX + 3); #1 check("pix.x3", is_timer, 3'b111);
      DrawX = 10'(BX + 4); #1 check("pix.x4", is_timer, 3'b101);
      DrawX = 10'(BX + 10); #1 check("pix.x10", is_timer, 3'b000);
      Stop = 1; DrawX = 10'(BX + 3); cycle("pix.stop");
      check("pix.idle", is_timer, 3'b000);

      Load = 1; cycle("rst.load");
      ticks(8, "rst.run");
      Reset = 0; cycle("rst.mid");
      check("rst.time", TimeLeft, 5);
      check("rst.running", Running, 0);
      Load = 1; cycle("rst2.load");
      ticks(19, "rst2.run");
      Reset = 0; tick = 1; cycle("rst2.expiring");
      check("rst2.noexp", Expired, 0);

      for (int i = 0; i < 3000; i++) begin
         DrawX = 10'(BX - 2 + int'($urandom_range(0, 14)));
         DrawY = 10'(BY - 2 + int'($urandom_range(0, 14)));
         tick = $urandom_range(0, 1) == 1;
         Load = $urandom_range(0, 99) < 3;
         Stop = $urandom_range(0, 99) < 1;
         Reset = $urandom_range(0, 199) != 0;
         AddTime = $urandom_range(0, 99) < 6;
         AddAmount = 8'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) Hold = ~Hold;
         cycle("rand");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
